// File: rtl/cp_insert.sv
// Cyclic-prefix insertion for OFDM TX.
// Ping-pong symbol buffer; emits CP tail then the body.
module cp_insert #(
  parameter int N_FFT = 64,
  parameter int N_CP  = 16,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_frame,
  input  logic [W-1:0] di_re,
  input  logic [W-1:0] di_im,
  input  logic         di_vld,
  output logic [W-1:0] do_re,
  output logic [W-1:0] do_im,
  output logic         do_vld,
  output logic         do_sop,
  output logic         ovf
);

  localparam int AW = $clog2(N_FFT);
  localparam logic [AW-1:0] CP0  = AW'(N_FFT - N_CP);
  localparam logic [AW-1:0] LAST = AW'(N_FFT - 1);

  typedef enum logic [1:0] {
    IDLE,
    CP,
    BODY
  } st_t;

  logic [2*W-1:0] mem [2*N_FFT];

  logic [AW-1:0] wcnt;
  logic          wb;
  logic          rb;
  logic [1:0]    full;
  logic [1:0]    full_d;
  logic          wr_en;
  logic          wr_last;

  st_t           st;
  st_t           st_d;
  logic [AW-1:0] rcnt;
  logic [AW-1:0] rcnt_d;
  logic          rd;
  logic          sop_d;
  logic          clr;

  assign wr_en   = di_vld & ~full[wb] & ~new_frame;
  assign wr_last = wr_en & (wcnt == LAST);

  // Full flags: a fill and a drain on the same edge both land.
  always_comb begin
    full_d = full;
    if (wr_last) full_d[wb] = 1'b1;
    if (clr)     full_d[rb] = 1'b0;
  end

  // Buffer storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb, wcnt}] <= {di_re, di_im};
  end

  // Write pointer, bank flags and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      wb   <= 1'b0;
      full <= 2'b00;
      ovf  <= 1'b0;
    end else if (new_frame) begin
      wcnt <= '0;
      wb   <= 1'b0;
      full <= 2'b00;
      ovf  <= 1'b0;
    end else begin
      full <= full_d;
      if (wr_en) begin
        wcnt <= wr_last ? '0 : wcnt + 1'b1;
        if (wr_last) wb <= ~wb;
      end
      if (di_vld && full[wb]) ovf <= 1'b1;
    end
  end

  // Read sequencer: CP tail, then body, chaining banks.
  always_comb begin
    st_d   = st;
    rcnt_d = rcnt;
    rd     = 1'b0;
    sop_d  = 1'b0;
    clr    = 1'b0;
    unique case (st)
      IDLE: begin
        if (full[rb]) begin
          st_d   = CP;
          rcnt_d = CP0;
        end
      end
      CP: begin
        rd    = 1'b1;
        sop_d = (rcnt == CP0);
        if (rcnt == LAST) begin
          st_d   = BODY;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt + 1'b1;
        end
      end
      BODY: begin
        rd = 1'b1;
        if (rcnt == LAST) begin
          clr = 1'b1;
          if (full[~rb]) begin
            st_d   = CP;
            rcnt_d = CP0;
          end else begin
            st_d   = IDLE;
            rcnt_d = '0;
          end
        end else begin
          rcnt_d = rcnt + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Sequencer state and read bank pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      rcnt <= '0;
      rb   <= 1'b0;
    end else if (new_frame) begin
      st   <= IDLE;
      rcnt <= '0;
      rb   <= 1'b0;
    end else begin
      st   <= st_d;
      rcnt <= rcnt_d;
      if (clr) rb <= ~rb;
    end
  end

  // Registered output; data holds while not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_re  <= '0;
      do_im  <= '0;
      do_vld <= 1'b0;
      do_sop <= 1'b0;
    end else if (new_frame) begin
      do_vld <= 1'b0;
      do_sop <= 1'b0;
    end else begin
      do_vld <= rd;
      do_sop <= sop_d;
      if (rd) {do_re, do_im} <= mem[{rb, rcnt}];
    end
  end

endmodule
